// File: rtl/my_xor_gate_pkg.sv
// Shared defaults for the my_xor_gate XOR/parity block
// and its saturating high-parity counter.
package my_xor_gate_pkg;

    localparam int XOR_WIDTH_DEF = 1;
    localparam int XOR_CNT_W_DEF = 16;

endpackage

// File: rtl/my_xor_gate_sat_cnt.sv
// Saturating up-counter with a synchronous active-low clear.
// Holds at all-ones instead of wrapping; sat flags that value.
module my_xor_gate_sat_cnt
    import my_xor_gate_pkg::*;
#(
    parameter int CNT_W = XOR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign sat   = w_sat;

endmodule

// File: rtl/my_xor_gate.sv
// Bitwise XOR with parity, a registered copy of the result,
// and a saturating count of cycles with odd parity.
module my_xor_gate
    import my_xor_gate_pkg::*;
#(
    parameter int WIDTH = XOR_WIDTH_DEF,
    parameter int CNT_W = XOR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic [WIDTH-1:0] o_C,
    output logic [WIDTH-1:0] o_C_q,
    output logic             o_parity,
    output logic [CNT_W-1:0] o_hi_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] w_c;
    logic             w_parity;
    logic [WIDTH-1:0] r_c_q;

    // Pure combinational path: X/Z on inputs propagates unmasked.
    assign w_c      = i_A ^ i_B;
    assign w_parity = ^w_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_c_q <= '0;
        end else begin
            r_c_q <= w_c;
        end
    end

    my_xor_gate_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_parity),
        .count (o_hi_count),
        .sat   (o_sat)
    );

    assign o_C      = w_c;
    assign o_C_q    = r_c_q;
    assign o_parity = w_parity;

endmodule

// File: tb/tb_my_xor_gate.sv
// Self-checking bench for my_xor_gate: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_my_xor_gate;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        a1 = 1'b0, b1 = 1'b0;
    logic        c1, cq1, p1, s1;
    logic [15:0] n1;

    logic        a3 = 1'b0, b3 = 1'b0;
    logic        c3, cq3, p3, s3;
    logic [2:0]  n3;

    logic [3:0]  a4 = '0, b4 = '0;
    logic [3:0]  c4, cq4;
    logic        p4, s4;
    logic [15:0] n4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    my_xor_gate #(.WIDTH(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .i_A(a1), .i_B(b1),
        .o_C(c1), .o_C_q(cq1), .o_parity(p1),
        .o_hi_count(n1), .o_sat(s1)
    );

    my_xor_gate #(.WIDTH(1), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .i_A(a3), .i_B(b3),
        .o_C(c3), .o_C_q(cq3), .o_parity(p3),
        .o_hi_count(n3), .o_sat(s3)
    );

    my_xor_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .reset(reset), .i_A(a4), .i_B(b4),
        .o_C(c4), .o_C_q(cq4), .o_parity(p4),
        .o_hi_count(n4), .o_sat(s4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (cq1 !== 1'b0 || n1 !== 16'd0 || s1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w1: cq=%b cnt=%0d sat=%b want 0/0/0",
                     cq1, n1, s1);
        end
        vectors++;
        if (cq3 !== 1'b0 || n3 !== 3'd0 || s3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c3: cq=%b cnt=%0d sat=%b want 0/0/0",
                     cq3, n3, s3);
        end
        vectors++;
        if (cq4 !== 4'd0 || n4 !== 16'd0 || s4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w4: cq=%b cnt=%0d sat=%b want 0/0/0",
                     cq4, n4, s4);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab;
        logic       exp;
        for (int v = 0; v < 4; v++) begin
            tick();
            ab = 2'(v);
            a1 = ab[1];
            b1 = ab[0];
            exp = (v == 1) || (v == 2);
            @(negedge clk);
            vectors++;
            if (c1 !== exp || p1 !== exp) begin
                miscompares++;
                $display("FAIL truth_%b: C=%b par=%b want %b",
                         ab, c1, p1, exp);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_register();
        do_reset();
        a1 = 1'b0;
        b1 = 1'b0;
        tick();
        a1 = 1'b0;
        b1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (cq1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reg_latency: C_q=%b want 0", cq1);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (cq1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reg_load: C_q=%b want 1", cq1);
        end
        reset = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (cq1 !== 1'b0 || c1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reg_reset: C_q=%b C=%b want 0 1", cq1, c1);
        end
        reset = 1'b1;
    endtask

    task automatic test_count_hold();
        do_reset();
        a1 = 1'b1;
        b1 = 1'b0;
        repeat (5) tick();
        a1 = 1'b1;
        b1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (n1 !== 16'd5) begin
            miscompares++;
            $display("FAIL count_5: cnt=%0d want 5", n1);
        end
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if (n1 !== 16'd5 || s1 !== 1'b0) begin
            miscompares++;
            $display("FAIL count_hold: cnt=%0d sat=%b want 5 0", n1, s1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        a3 = 1'b0;
        b3 = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        vectors++;
        if (n3 !== 3'd7 || s3 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hold: cnt=%0d sat=%b want 7 1", n3, s3);
        end
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (n3 !== 3'd0 || s3 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear: cnt=%0d sat=%b want 0 0", n3, s3);
        end
        reset = 1'b1;
    endtask

    task automatic test_width4();
        tick();
        a4 = 4'b1100;
        b4 = 4'b1010;
        @(negedge clk);
        vectors++;
        if (c4 !== 4'b0110 || p4 !== 1'b0) begin
            miscompares++;
            $display("FAIL w4_even: C=%b par=%b want 0110 0", c4, p4);
        end
        tick();
        b4 = 4'b1000;
        @(negedge clk);
        vectors++;
        if (c4 !== 4'b0100 || p4 !== 1'b1) begin
            miscompares++;
            $display("FAIL w4_odd: C=%b par=%b want 0100 1", c4, p4);
        end
    endtask

    task automatic test_random();
        int   e1, e3, e4;
        logic q1, q3;
        logic [3:0] q4, x4;
        logic par4;
        do_reset();
        e1 = 0; e3 = 0; e4 = 0;
        q1 = 1'b0; q3 = 1'b0; q4 = '0;
        for (int i = 0; i < 300; i++) begin
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a3 = ($urandom_range(0, 3) != 0) ? ~b3 : b3;
            b3 = 1'($urandom);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            reset = ($urandom_range(0, 24) != 0);
            x4 = a4 ^ b4;
            par4 = ($countones(x4) % 2) == 1;
            @(negedge clk);
            vectors++;
            if (c1 !== (a1 != b1) || cq1 !== q1 || n1 !== 16'(e1)
                || s1 !== (e1 == 65535)) begin
                miscompares++;
                $display("FAIL rand_w1 #%0d: C=%b Cq=%b cnt=%0d want %b %b %0d",
                         i, c1, cq1, n1, a1 != b1, q1, e1);
            end
            vectors++;
            if (c3 !== (a3 != b3) || cq3 !== q3 || n3 !== 3'(e3)
                || s3 !== (e3 == 7)) begin
                miscompares++;
                $display("FAIL rand_c3 #%0d: C=%b Cq=%b cnt=%0d sat=%b want %b %b %0d",
                         i, c3, cq3, n3, s3, a3 != b3, q3, e3);
            end
            vectors++;
            if (c4 !== x4 || p4 !== par4 || cq4 !== q4
                || n4 !== 16'(e4)) begin
                miscompares++;
                $display("FAIL rand_w4 #%0d: C=%b par=%b Cq=%b cnt=%0d want %b %b %b %0d",
                         i, c4, p4, cq4, n4, x4, par4, q4, e4);
            end
            if (!reset) begin
                e1 = 0; e3 = 0; e4 = 0;
                q1 = 1'b0; q3 = 1'b0; q4 = '0;
            end else begin
                q1 = a1 ^ b1;
                q3 = a3 ^ b3;
                q4 = x4;
                if (a1 != b1) e1 = (e1 < 65535) ? e1 + 1 : e1;
                if (a3 != b3) e3 = (e3 < 7) ? e3 + 1 : e3;
                if (par4) e4 = (e4 < 65535) ? e4 + 1 : e4;
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_register();
        test_count_hold();
        test_saturation();
        test_width4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
